// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two requesters, one op in flight.
// ALU_ARB_BYPASS_EN: drive the ALU straight from the winner, skip EXEC.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [CTRL_W-1:0] alu_control,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t            state;
  logic              last;
  logic [CTRL_W-1:0] op_ctrl;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  logic              idle;
  logic              any_v;
  logic              sel1;
  logic [CTRL_W-1:0] win_ctrl;
  logic [DATA_W-1:0] win_a;
  logic [DATA_W-1:0] win_b;

  assign idle  = (state == IDLE);
  assign any_v = req0_valid | req1_valid;

  // requester 1 wins when alone, or on a tie if 0 went last
  assign sel1 = req1_valid & (~req0_valid | ~last);

  assign req0_ready = idle & req0_valid & ~sel1;
  assign req1_ready = idle & sel1;

  always_comb begin
    win_ctrl = req0_ctrl;
    win_a    = req0_a;
    win_b    = req0_b;
    unique case (1'b1)
      sel1: begin
        win_ctrl = req1_ctrl;
        win_a    = req1_a;
        win_b    = req1_b;
      end
      default: ;
    endcase
  end

`ifdef ALU_ARB_BYPASS_EN
  always_comb begin
    alu_control = op_ctrl;
    alu_a       = op_a;
    alu_b       = op_b;
    if (idle && any_v) begin
      alu_control = win_ctrl;
      alu_a       = win_a;
      alu_b       = win_b;
    end
  end
`else
  assign alu_control = op_ctrl;
  assign alu_a       = op_a;
  assign alu_b       = op_b;
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= IDLE;
      last       <= 1'b1;
      op_ctrl    <= '0;
      op_a       <= '0;
      op_b       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_v) begin
            op_ctrl <= win_ctrl;
            op_a    <= win_a;
            op_b    <= win_b;
            last    <= sel1;
`ifdef ALU_ARB_BYPASS_EN
            rsp_valid  <= 1'b1;
            rsp_id     <= sel1;
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            state      <= RESP;
`else
            state <= EXEC;
`endif
          end
        end
        EXEC: begin
          // last already holds the ID of the op in flight
          rsp_valid  <= 1'b1;
          rsp_id     <= last;
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: transaction model plus directed vectors.
// Works with and without ALU_ARB_BYPASS_EN.
module tb_alu_share_arbiter;

`ifdef ALU_ARB_BYPASS_EN
  localparam bit BYP     = 1'b1;
  localparam int RSP_LAT = 1;
`else
  localparam bit BYP     = 1'b0;
  localparam int RSP_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [31:0] rsp_result;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int          gr_q[$];
  int          rs_id[$];
  logic [31:0] rs_res[$];
  logic        rs_z[$];

  alu_share_arbiter #(.DATA_W(32), .CTRL_W(4)) dut (
    .clk(clk), .arst(arst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_ctrl(req0_ctrl), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_ctrl(req1_ctrl), .req1_a(req1_a), .req1_b(req1_b),
    .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(
    input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd3: return a << b[4:0];
      4'd4: return a >> b[4:0];
      4'd6: return a - b;
      4'd7: return {31'b0, $signed(a) < $signed(b)};
      default: return 32'h0;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_f(alu_control, alu_a, alu_b);
    alu_zero   = (alu_result == 32'h0);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out", nm);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake log, sampled on the edge where the transfer happens
  always @(posedge clk) begin
    if (!arst) begin
      if (req0_valid && req0_ready) gr_q.push_back(0);
      if (req1_valid && req1_ready) gr_q.push_back(1);
      if (rsp_valid && rsp_ready) begin
        rs_id.push_back(int'(rsp_id));
        rs_res.push_back(rsp_result);
        rs_z.push_back(rsp_zero);
      end
    end
  end

  // Transaction model: one op outstanding, due RSP_LAT cycles after grant
  logic        m_busy, m_last, m_eid, m_ez;
  logic [3:0]  m_ctrl;
  logic [31:0] m_a, m_b, m_eres;
  int          m_due;

  always @(negedge clk) begin
    logic        w, anyv, ev;
    logic [3:0]  wc, ec;
    logic [31:0] wa, wb, ea, eb;
    if (arst) begin
      m_busy = 1'b0;
      m_last = 1'b1;
      m_ctrl = 4'h0;
      m_a    = 32'h0;
      m_b    = 32'h0;
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_zero", rsp_zero, 0);
    end
    anyv = req0_valid | req1_valid;
    w    = (req0_valid && req1_valid) ? !m_last : req1_valid;
    wc   = w ? req1_ctrl : req0_ctrl;
    wa   = w ? req1_a : req0_a;
    wb   = w ? req1_b : req0_b;
    chk("m_rdy0", req0_ready, !m_busy && req0_valid && !w);
    chk("m_rdy1", req1_ready, !m_busy && req1_valid && w);
    ec = m_ctrl;
    ea = m_a;
    eb = m_b;
    if (BYP && !m_busy && anyv) begin
      ec = wc;
      ea = wa;
      eb = wb;
    end
    chk("m_alu_ctrl", alu_control, ec);
    chk("m_alu_a", alu_a, ea);
    chk("m_alu_b", alu_b, eb);
    ev = m_busy && (cyc >= m_due);
    chk("m_rsp_valid", rsp_valid, ev);
    if (ev) begin
      chk("m_rsp_id", rsp_id, m_eid);
      chk("m_rsp_result", rsp_result, m_eres);
      chk("m_rsp_zero", rsp_zero, m_ez);
    end
    if (!arst) begin
      if (ev && rsp_ready) begin
        m_busy = 1'b0;
      end else if (!m_busy && anyv) begin
        m_busy = 1'b1;
        m_last = w;
        m_ctrl = wc;
        m_a    = wa;
        m_b    = wb;
        m_eid  = w;
        m_eres = alu_f(wc, wa, wb);
        m_ez   = (m_eres == 32'h0);
        m_due  = cyc + RSP_LAT;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit id, input logic v,
                         input logic [3:0] c,
                         input logic [31:0] a,
                         input logic [31:0] b);
    if (id) begin
      req1_valid = v; req1_ctrl = c;
      req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_ctrl = c;
      req0_a = a; req0_b = b;
    end
  endtask

  // Raise valid, wait for ready, drop valid after the accept edge
  task automatic issue(input bit id, input logic [3:0] c,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       output int acc);
    bit done;
    done = 1'b0;
    acc = 0;
    set_req(id, 1'b1, c, a, b);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = id ? req1_ready : req0_ready;
      acc = cyc;
    end
    if (!done) timeout("issue");
    tick();
    set_req(id, 1'b0, c, a, b);
  endtask

  task automatic wait_rsp_count(input int n);
    int i;
    i = 0;
    while (rs_id.size() < n && i < 40) begin
      tick();
      i++;
    end
    if (rs_id.size() < n) timeout("wait_rsp");
  endtask

  task automatic wait_valid();
    int i;
    i = 0;
    @(negedge clk);
    while (!rsp_valid && i < 20) begin
      @(negedge clk);
      i++;
    end
    if (!rsp_valid) timeout("wait_valid");
  endtask

  task automatic op1(input string nm, input logic [3:0] c,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp);
    int r0, acc;
    r0 = rs_id.size();
    issue(1'b1, c, a, b, acc);
    wait_rsp_count(r0 + 1);
    if (rs_id.size() > r0) begin
      chk(nm, rs_res[r0], exp);
      chk({nm, "_id"}, rs_id[r0], 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, r0, g0, t0, eg[4];
    logic [31:0] er[4];
    eg = '{0, 1, 0, 1};
    er = '{32'h0, 32'hFF, 32'h0, 32'hFF};
    set_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    rsp_ready = 1'b1;
    #1 arst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("reset_valid", rsp_valid, 0);
    chk("reset_id", rsp_id, 0);
    chk("reset_result", rsp_result, 0);
    chk("reset_zero", rsp_zero, 0);
    chk("reset_alu_ctrl", alu_control, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_b", alu_b, 0);
    chk("reset_rdy0", req0_ready, 0);
    chk("reset_rdy1", req1_ready, 0);
    tick();
    arst = 1'b0;
    tick();

    // Reset in the middle of an op
    r0 = rs_id.size();
    issue(1'b0, 4'd2, 32'd5, 32'd7, acc);
    arst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", rsp_valid, 0);
    chk("midrst_alu_a", alu_a, 0);
    chk("midrst_alu_b", alu_b, 0);
    tick();
    arst = 1'b0;
    repeat (6) tick();
    chk("midrst_no_rsp", rs_id.size(), r0);

    // Round robin with both held
    g0 = gr_q.size();
    r0 = rs_id.size();
    set_req(1'b0, 1'b1, 4'd6, 32'd9, 32'd9);
    set_req(1'b1, 1'b1, 4'd1, 32'hF0, 32'h0F);
    t0 = 0;
    while (gr_q.size() < g0 + 4 && t0 < 40) begin
      tick();
      t0++;
    end
    if (gr_q.size() < g0 + 4) timeout("rr_grants");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp_count(r0 + 4);
    for (int k = 0; k < 4; k++) begin
      if (gr_q.size() > g0 + k)
        chk($sformatf("rr_grant%0d", k), gr_q[g0 + k], eg[k]);
      if (rs_id.size() > r0 + k) begin
        chk($sformatf("rr_id%0d", k), rs_id[r0 + k], eg[k]);
        chk($sformatf("rr_res%0d", k), rs_res[r0 + k], er[k]);
        chk($sformatf("rr_z%0d", k), rs_z[r0 + k], (k % 2) == 0);
      end
    end
    repeat (2) tick();

    // Single op latency and result
    issue(1'b0, 4'd2, 32'd5, 32'd7, acc);
    wait_valid();
    chk("single_latency", cyc - acc, RSP_LAT);
    chk("single_result", rsp_result, 32'd12);
    chk("single_zero", rsp_zero, 0);
    chk("single_id", rsp_id, 0);
    repeat (2) tick();

    // Back-pressure with both requesters waiting
    rsp_ready = 1'b0;
    r0 = rs_id.size();
    issue(1'b0, 4'd2, 32'd3, 32'd4, acc);
    wait_valid();
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b1, 4'd0, 32'd1, 32'd1);
    set_req(1'b1, 1'b1, 4'd2, 32'd2, 32'd2);
    repeat (4) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_result", rsp_result, 32'd7);
      chk("bp_rdy0", req0_ready, 0);
      chk("bp_rdy1", req1_ready, 0);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_still_valid", rsp_valid, 1);
    tick();
    @(negedge clk);
    chk("bp_released", rsp_valid, 0);
    chk("bp_one_ready", req0_ready + req1_ready, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp_count(r0 + 2);
    if (rs_id.size() > r0 + 1) begin
      chk("bp_next_id", rs_id[r0 + 1], 1);
      chk("bp_next_res", rs_res[r0 + 1], 32'd4);
    end
    repeat (2) tick();

    // Abandoned request from requester 1
    rsp_ready = 1'b0;
    g0 = gr_q.size();
    r0 = rs_id.size();
    issue(1'b0, 4'd2, 32'd1, 32'd1, acc);
    wait_valid();
    tick();
    set_req(1'b1, 1'b1, 4'd2, 32'd8, 32'd8);
    tick();
    req1_valid = 1'b0;
    repeat (2) tick();
    rsp_ready = 1'b1;
    repeat (5) tick();
    chk("abandon_grants", gr_q.size() - g0, 1);
    chk("abandon_rsps", rs_id.size() - r0, 1);
    if (rs_id.size() > r0) chk("abandon_id", rs_id[r0], 0);

    // Opcodes through requester 1
    op1("op_slt", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'd1);
    op1("op_sll", 4'd3, 32'd1, 32'd4, 32'd16);
    op1("op_srl", 4'd4, 32'h8000_0000, 32'd31, 32'd1);
    op1("op_and", 4'd0, 32'hC, 32'hA, 32'h8);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
